// File: rtl/user_reg_hub.sv
// Register-interface hub: fans one host register port out to NUM_SLAVES slaves,
// and always answers a read, with an error word on a decode miss or a timeout.
module user_reg_hub #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SLV_ADDR_W = 16,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                         i_user_clk,
  input  logic                         i_rst_n,
  input  logic [ADDR_W-1:0]            i_user_addr,
  input  logic [DATA_W-1:0]            i_user_data,
  input  logic                         i_user_wr_req,
  input  logic                         i_user_rd_req,
  output logic [DATA_W-1:0]            o_user_data,
  output logic                         o_user_rd_ack,
  output logic [SLV_ADDR_W-1:0]        o_slv_addr,
  output logic [DATA_W-1:0]            o_slv_data,
  output logic [NUM_SLAVES-1:0]        o_slv_wr_req,
  output logic [NUM_SLAVES-1:0]        o_slv_rd_req,
  input  logic [NUM_SLAVES*DATA_W-1:0] i_slv_data,
  input  logic [NUM_SLAVES-1:0]        i_slv_rd_ack,
  input  logic                         i_err_clr,
  output logic                         o_err,
  output logic [7:0]                   o_timeout_cnt
);

  localparam int unsigned       SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [SEL_W:0]    NUM_SLV_W  = (SEL_W + 1)'(NUM_SLAVES);
  localparam logic [15:0]       TIMEOUT_W  = 16'(TIMEOUT);
  localparam logic [DATA_W-1:0] ERR_WORD   = DATA_W'(ERR_DATA);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [15:0]             wait_q, wait_d;
  logic [DATA_W-1:0]       resp_data_q, resp_data_d;
  logic [DATA_W-1:0]       user_data_q, user_data_d;
  logic                    user_rd_ack_q, user_rd_ack_d;
  logic [SLV_ADDR_W-1:0]   slv_addr_q, slv_addr_d;
  logic [DATA_W-1:0]       slv_data_q, slv_data_d;
  logic [NUM_SLAVES-1:0]   slv_wr_q, slv_wr_d;
  logic [NUM_SLAVES-1:0]   slv_rd_q, slv_rd_d;
  logic                    err_q, err_d;
  logic [7:0]              tcnt_q, tcnt_d;

  logic [SEL_W-1:0]        sel;
  logic                    hit;
  logic [NUM_SLAVES-1:0]   sel_oh;
  logic                    ack_sel;
  logic [DATA_W-1:0]       rdata_sel;
  logic                    err_set;
  logic                    timeout;

  assign sel = i_user_addr[SLV_ADDR_W +: SEL_W];
  assign hit = ({1'b0, sel} < NUM_SLV_W);

  if (ADDR_W > SLV_ADDR_W + SEL_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_user_addr[ADDR_W-1:SLV_ADDR_W+SEL_W];
  end

  // Request one-hot decode, plus ack/data mux for the slave latched at read issue.
  always_comb begin
    sel_oh    = '0;
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      sel_oh[k] = (sel == SEL_W'(k));
      if (sel_q == SEL_W'(k)) begin
        ack_sel   = i_slv_rd_ack[k];
        rdata_sel = i_slv_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    sel_d         = sel_q;
    wait_d        = wait_q;
    resp_data_d   = resp_data_q;
    user_data_d   = user_data_q;
    user_rd_ack_d = 1'b0;
    slv_addr_d    = slv_addr_q;
    slv_data_d    = slv_data_q;
    slv_wr_d      = '0;
    slv_rd_d      = '0;
    err_set       = 1'b0;
    timeout       = 1'b0;

    if (i_user_wr_req) begin
      if (hit) begin
        slv_wr_d   = sel_oh;
        slv_addr_d = i_user_addr[SLV_ADDR_W-1:0];
        slv_data_d = i_user_data;
      end else begin
        err_set = 1'b1;
      end
    end

    // Only one read may be outstanding; a read arriving mid-transaction is dropped.
    if (i_user_rd_req && (state_q != IDLE)) err_set = 1'b1;

    case (state_q)
      IDLE: begin
        if (i_user_rd_req) begin
          if (hit) begin
            slv_rd_d   = sel_oh;
            slv_addr_d = i_user_addr[SLV_ADDR_W-1:0];
            sel_d      = sel;
            wait_d     = '0;
            state_d    = RD_WAIT;
          end else begin
            resp_data_d = ERR_WORD;
            err_set     = 1'b1;
            state_d     = RESP;
          end
        end
      end
      RD_WAIT: begin
        if (ack_sel) begin
          resp_data_d = rdata_sel;
          state_d     = RESP;
        end else begin
          wait_d = wait_q + 16'd1;
          if (wait_d == TIMEOUT_W) begin
            resp_data_d = ERR_WORD;
            err_set     = 1'b1;
            timeout     = 1'b1;
            state_d     = RESP;
          end
        end
      end
      RESP: begin
        user_rd_ack_d = 1'b1;
        user_data_d   = resp_data_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A set event in the same cycle as a clear wins.
    err_d  = err_set | (err_q & ~i_err_clr);
    tcnt_d = i_err_clr ? 8'd0 : tcnt_q;
    if (timeout && (tcnt_d != 8'hFF)) tcnt_d = tcnt_d + 8'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_user_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      wait_q        <= '0;
      resp_data_q   <= '0;
      user_data_q   <= '0;
      user_rd_ack_q <= 1'b0;
      slv_addr_q    <= '0;
      slv_data_q    <= '0;
      slv_wr_q      <= '0;
      slv_rd_q      <= '0;
      err_q         <= 1'b0;
      tcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      wait_q        <= wait_d;
      resp_data_q   <= resp_data_d;
      user_data_q   <= user_data_d;
      user_rd_ack_q <= user_rd_ack_d;
      slv_addr_q    <= slv_addr_d;
      slv_data_q    <= slv_data_d;
      slv_wr_q      <= slv_wr_d;
      slv_rd_q      <= slv_rd_d;
      err_q         <= err_d;
      tcnt_q        <= tcnt_d;
    end
  end

  assign o_user_data   = user_data_q;
  assign o_user_rd_ack = user_rd_ack_q;
  assign o_slv_addr    = slv_addr_q;
  assign o_slv_data    = slv_data_q;
  assign o_slv_wr_req  = slv_wr_q;
  assign o_slv_rd_req  = slv_rd_q;
  assign o_err         = err_q;
  assign o_timeout_cnt = tcnt_q;

endmodule

// File: doc/user_reg_hub.md
# user_reg_hub

Parametrised register-interface hub that sits between the PCIe core's single user register port and `NUM_SLAVES` independent user register slaves. It decodes the upper address bits to pick a slave, forwards write and read strobes as single-cycle pulses, and collects the selected slave's read acknowledge and data. It returns a defined error word on decode misses and read timeouts, and keeps sticky error status and a timeout counter. The hub always answers a read, so a missing or hung slave can no longer stall the host.

## Interface
Parameters:
- `NUM_SLAVES`, 4: number of slave ports, 1..16.
- `ADDR_W`, 20: width of the incoming user address.
- `DATA_W`, 32: register data width.
- `SLV_ADDR_W`, 16: slave-local address width. Slave select is `i_user_addr[SLV_ADDR_W +: SEL_W]`, where `SEL_W = max(1, clog2(NUM_SLAVES))`.
- `TIMEOUT`, 255: cycles to wait for a slave read ack, 1..65535.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on a decode miss or timeout, truncated or zero-extended to `DATA_W`.

Ports:
- `i_user_clk`, in, 1: the single clock; every flop is clocked on the rising edge.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_user_addr`, in, `ADDR_W`: request address, valid while a request strobe is high.
- `i_user_data`, in, `DATA_W`: write data, valid with `i_user_wr_req`.
- `i_user_wr_req`, in, 1: single-cycle write strobe.
- `i_user_rd_req`, in, 1: single-cycle read strobe.
- `o_user_data`, out, `DATA_W`: read response data, valid with `o_user_rd_ack`.
- `o_user_rd_ack`, out, 1: single-cycle read response strobe.
- `o_slv_addr`, out, `SLV_ADDR_W`: registered slave-local address.
- `o_slv_data`, out, `DATA_W`: registered write data.
- `o_slv_wr_req`, out, `NUM_SLAVES`: one-hot write pulse.
- `o_slv_rd_req`, out, `NUM_SLAVES`: one-hot read pulse.
- `i_slv_data`, in, `NUM_SLAVES*DATA_W`: slave read data; slave k drives `[k*DATA_W +: DATA_W]`.
- `i_slv_rd_ack`, in, `NUM_SLAVES`: per-slave read-ack pulses.
- `i_err_clr`, in, 1: clears `o_err` and `o_timeout_cnt`.
- `o_err`, out, 1: sticky flag, set on a decode miss, a timeout, or a dropped read.
- `o_timeout_cnt`, out, 8: saturating count of read timeouts.

## Operation
- **Reset.** All outputs are 0, the FSM is in IDLE and the wait counter is 0.
- **Decode.** `sel = i_user_addr[SLV_ADDR_W +: SEL_W]`. If `sel >= NUM_SLAVES`, the request is a decode miss.
- **Writes** are accepted in every state.
  - A valid write registers the address and data and pulses `o_slv_wr_req[sel]`.
  - A decode-miss write is dropped and sets `o_err`.
- **FSM states.** IDLE, RD_WAIT, RESP.
  - IDLE, valid read: register the address, pulse `o_slv_rd_req[sel]`, latch `sel`, clear the wait counter, go to RD_WAIT.
  - IDLE, decode-miss read: load `ERR_DATA`, set `o_err`, go to RESP.
  - RD_WAIT, `i_slv_rd_ack[sel_q]` seen: capture that slave's data slice, go to RESP.
  - RD_WAIT, wait counter reaches `TIMEOUT` with no ack: load `ERR_DATA`, set `o_err`, increment `o_timeout_cnt` (saturating at 255), go to RESP.
  - RESP: pulse `o_user_rd_ack` with `o_user_data`, return to IDLE.
- **Ack filtering.** Acks from non-selected slaves, and any ack received outside RD_WAIT, are ignored.
- **Overlapping reads.** A read request arriving in RD_WAIT or RESP is dropped and sets `o_err`. No response is issued for it.
- **Write and read in the same cycle.** Both use the same address. The write pulse and the read pulse go out in the same cycle.
- **`o_user_data`** holds its last value between acks.
- **`i_err_clr`** clears `o_err` and `o_timeout_cnt`. If a set event occurs in the same cycle, the set wins, and a timeout in that cycle leaves the counter at 1.
- **Reset mid-read.** Asserting `i_rst_n` low aborts the read with no ack. A later slave ack is ignored.

## Timing
- **Write.** A request at edge N produces `o_slv_wr_req` high for exactly one cycle after edge N+1. `o_slv_addr` and `o_slv_data` are valid in that same cycle.
- **Read forward.** A request at edge N produces `o_slv_rd_req` high for one cycle after edge N+1.
- **Read response.** An ack sampled at edge M (M ≥ N+2) produces `o_user_rd_ack` after edge M+1, so the minimum read latency is 3 cycles.
- **Timeout.** With no ack, `o_user_rd_ack` asserts after edge N+2+TIMEOUT.
- **Decode-miss read.** `o_user_rd_ack` asserts after edge N+2.
- **Outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Write fan-out.** With `NUM_SLAVES=4`, `SLV_ADDR_W=16`: write addr 0x2_0010, data 0x1234_5678 → `o_slv_wr_req = 4'b0100` for one cycle, `o_slv_addr = 0x0010`, `o_slv_data = 0x1234_5678`.
- **Read.** Read addr 0x1_0004, slave 1 acks 2 cycles after its `o_slv_rd_req` with 0xCAFE_0001 → `o_user_rd_ack` one cycle after the slave ack, `o_user_data = 0xCAFE_0001`, `o_err = 0`.
- **Timeout.** With `TIMEOUT=8`, read slave 3 with no ack → ack after edge N+10 with 0xDEAD_BEEF, `o_err = 1`, `o_timeout_cnt = 1`. A late slave-3 ack is ignored.
- **Decode miss.** With `NUM_SLAVES=3`: read addr 0x3_0000 → ERR_DATA after edge N+2, no `o_slv_rd_req`. A write to the same address produces no `o_slv_wr_req` and sets `o_err`.
- **Overlap.** A second read issued in RD_WAIT → exactly one `o_user_rd_ack` (the first read's), `o_err = 1`. A write in RD_WAIT is still forwarded.
- **Reset and clear.** `i_rst_n` low during RD_WAIT → all outputs 0, no ack. After 256 timeouts `o_timeout_cnt` stays at 255. `i_err_clr` → `o_err = 0`, `o_timeout_cnt = 0`.
